// File: rtl/stream_rr_arbiter_pkg.sv
// Shared types and the reference round-robin pick for the stream arbiter.
// rr_pick works on a fixed maximum width so that any A up to RR_MAX_A can use it.
package stream_rr_arbiter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    localparam int RR_MAX_A = 8;
    localparam int RR_MAX_D = 1 << RR_MAX_A;

    // First set bit of valid, searching upward from ptr+1 mod 2**a_w and wrapping.
    function automatic logic [RR_MAX_A-1:0] rr_pick(
        input logic [RR_MAX_D-1:0] valid,
        input logic [RR_MAX_A-1:0] ptr,
        input int                  a_w
    );
        int                  d;
        logic                found;
        logic [RR_MAX_A-1:0] idx;
        logic [RR_MAX_A-1:0] pick;
        d     = 1 << a_w;
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= RR_MAX_D; k++) begin
            idx = RR_MAX_A'((int'(ptr) + k) % d);
            if (k <= d && !found && valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// Handshake bundle between the requesting streams and the arbiter.
// The slave side is the arbiter; the master side drives requests and out_ready.
interface stream_rr_arbiter_if #(
    parameter int A = 1,
    parameter int C = 16
);
    localparam int D = 2 ** A;

    logic [D-1:0] in_valid;
    logic [D-1:0] in_last;
    logic [D-1:0] in_ready;
    logic [A-1:0] select;
    logic         out_valid;
    logic         out_last;
    logic         out_ready;
    logic         busy;
    logic [C-1:0] beat_cnt;

    modport master (
        output in_valid, in_last, out_ready,
        input  in_ready, select, out_valid, out_last, busy, beat_cnt
    );

    modport slave (
        input  in_valid, in_last, out_ready,
        output in_ready, select, out_valid, out_last, busy, beat_cnt
    );
endinterface

// File: rtl/stream_rr_arbiter_rr_pick_comb.sv
// Combinational round-robin pick: rotate requests so ptr+1 sits at bit 0,
// take the lowest set bit, then rotate the offset back into an absolute index.
module rr_pick_comb #(
    parameter int A = 1,
    parameter int D = 2 ** A
) (
    input  logic [D-1:0] valid_i,
    input  logic [A-1:0] ptr_i,
    output logic [A-1:0] idx_o,
    output logic         any_o
);
    logic [D-1:0] rot;
    logic [A-1:0] off;

    // D is a power of two, so A-bit addition wraps exactly like mod D.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_rot
            logic [A-1:0] src;
            assign src     = ptr_i + A'(gi) + A'(1);
            assign rot[gi] = valid_i[src];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int i = D - 1; i >= 0; i--) begin
            if (rot[i]) off = A'(i);
        end
    end

    assign idx_o = ptr_i + off + A'(1);
    assign any_o = |valid_i;
endmodule

// File: rtl/stream_rr_arbiter.sv
// Packet-locked round-robin arbiter: grants one stream per packet and produces
// the registered select for the downstream data mux.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int A = 1,
    parameter int D = 2 ** A,
    parameter int C = 16
) (
    input logic           aclk,
    input logic           aresetn,
    stream_rr_arbiter_if.slave bus
);
    arb_state_t   state_q, state_d;
    logic [A-1:0] select_q, select_d;
    logic [A-1:0] ptr_q, ptr_d;
    logic [C-1:0] cnt_q, cnt_d;
    logic [A-1:0] pick;
    logic         any_req;
    logic         locked;
    logic         cur_valid;
    logic         cur_last;
    logic         xfer;
    logic [D-1:0] ready_vec;

    rr_pick_comb #(
        .A (A),
        .D (D)
    ) u_pick (
        .valid_i (bus.in_valid),
        .ptr_i   (ptr_q),
        .idx_o   (pick),
        .any_o   (any_req)
    );

    assign locked    = (state_q == LOCKED);
    assign cur_valid = bus.in_valid[select_q];
    assign cur_last  = bus.in_last[select_q];
    assign xfer      = locked & cur_valid & bus.out_ready;

    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_ready
            assign ready_vec[gi] = locked && (select_q == A'(gi)) && bus.out_ready;
        end
    endgenerate

    assign bus.in_ready  = ready_vec;
    assign bus.out_valid = locked & cur_valid;
    assign bus.out_last  = locked & cur_last;
    assign bus.busy      = locked;
    assign bus.select    = select_q;
    assign bus.beat_cnt  = cnt_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            select_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            select_q <= select_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // select only moves on IDLE->LOCKED, keeping the mux steady for a whole packet.
    always_comb begin
        state_d  = state_q;
        select_d = select_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    select_d = pick;
                    state_d  = LOCKED;
                end
            end
            LOCKED: begin
                if (xfer) begin
                    if (cur_last) begin
                        state_d = IDLE;
                        ptr_d   = select_q;
                        cnt_d   = '0;
                    end else if (cnt_q != {C{1'b1}}) begin
                        cnt_d = cnt_q + C'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: a 4-requester instance and a
// 2-requester instance with a narrow beat counter to reach saturation.
module tb_stream_rr_arbiter;
    import stream_rr_arbiter_pkg::*;

    logic aclk;
    logic aresetn;
    int   total;
    int   bad;

    stream_rr_arbiter_if #(.A(2), .C(16)) bus2 ();
    stream_rr_arbiter_if #(.A(1), .C(3))  bus1 ();

    stream_rr_arbiter #(.A(2), .C(16)) dut2 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus2.slave)
    );

    stream_rr_arbiter #(.A(1), .C(3)) dut1 (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus1.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int                  order [5];
        int                  beats;
        logic [RR_MAX_D-1:0] vmodel;
        logic [RR_MAX_A-1:0] exp_pick;

        total = 0;
        bad   = 0;
        order = '{1, 2, 3, 0, 1};

        aresetn        = 1'b0;
        bus2.in_valid  = '0;
        bus2.in_last   = '0;
        bus2.out_ready = 1'b0;
        bus1.in_valid  = '0;
        bus1.in_last   = '0;
        bus1.out_ready = 1'b0;

        // 1: held in reset, nothing requesting
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t1_busy", bus2.busy, 0);
            check("t1_ready", bus2.in_ready, 0);
            check("t1_select", bus2.select, 0);
            check("t1_oval", bus2.out_valid, 0);
            $display("t1 cycle %0d busy=%0b ready=%b select=%0d", c, bus2.busy, bus2.in_ready, bus2.select);
        end
        aresetn = 1'b1;
        tick();
        check("t1_idle_busy", bus2.busy, 0);
        check("t1_idle_cnt", bus2.beat_cnt, 0);

        // 2: all four requesting, 2-beat packets
        bus2.in_valid  = 4'hF;
        bus2.in_last   = 4'h0;
        bus2.out_ready = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick();
            check("t2_select", bus2.select, order[p]);
            check("t2_busy", bus2.busy, 1);
            check("t2_ready", bus2.in_ready, 32'd1 << order[p]);
            check("t2_cnt0", bus2.beat_cnt, 0);
            tick();
            bus2.in_last = 4'hF;
            #1;
            check("t2_cnt1", bus2.beat_cnt, 1);
            check("t2_olast", bus2.out_last, 1);
            check("t2_select_hold", bus2.select, order[p]);
            tick();
            bus2.in_last = 4'h0;
            check("t2_done_busy", bus2.busy, 0);
            check("t2_done_cnt", bus2.beat_cnt, 0);
            check("t2_done_ready", bus2.in_ready, 0);
            $display("t2 packet %0d granted=%0d", p, bus2.select);
        end
        bus2.in_valid = 4'h0;

        // 3: only req 2, 5 beats, out_ready toggling
        bus2.in_valid = 4'b0100;
        tick();
        check("t3_select", bus2.select, 2);
        beats = 0;
        for (int cyc = 0; cyc < 20 && beats < 5; cyc++) begin
            bus2.out_ready = (cyc % 2 == 0);
            bus2.in_last   = (beats == 4) ? 4'b0100 : 4'b0000;
            #1;
            check("t3_ready", bus2.in_ready, bus2.out_ready ? 4'b0100 : 4'b0000);
            check("t3_cnt", bus2.beat_cnt, beats);
            check("t3_busy", bus2.busy, 1);
            $display("t3 cycle %0d out_ready=%0b beat_cnt=%0d", cyc, bus2.out_ready, bus2.beat_cnt);
            tick();
            if (bus2.out_ready) beats++;
        end
        check("t3_end_busy", bus2.busy, 0);
        check("t3_end_cnt", bus2.beat_cnt, 0);
        bus2.out_ready = 1'b1;
        bus2.in_valid  = 4'h0;
        bus2.in_last   = 4'h0;

        // 4: req 3 locked, req 0 arrives mid-packet, plus a bubble
        bus2.in_valid = 4'b1000;
        tick();
        check("t4_select", bus2.select, 3);
        check("t4_cnt0", bus2.beat_cnt, 0);
        tick();
        bus2.in_valid = 4'b1001;
        #1;
        check("t4_ready", bus2.in_ready, 4'b1000);
        check("t4_cnt1", bus2.beat_cnt, 1);
        bus2.in_valid = 4'b0001;
        #1;
        check("t4_bubble_oval", bus2.out_valid, 0);
        check("t4_bubble_busy", bus2.busy, 1);
        tick();
        check("t4_bubble_cnt", bus2.beat_cnt, 1);
        check("t4_bubble_sel", bus2.select, 3);
        bus2.in_valid = 4'b1001;
        bus2.in_last  = 4'b1000;
        #1;
        check("t4_olast", bus2.out_last, 1);
        check("t4_oval", bus2.out_valid, 1);
        tick();
        bus2.in_last = 4'h0;
        check("t4_done_busy", bus2.busy, 0);
        check("t4_done_sel", bus2.select, 3);
        vmodel      = '0;
        vmodel[3:0] = 4'b1001;
        exp_pick    = rr_pick(vmodel, RR_MAX_A'(3), 2);
        tick();
        check("t4_next_sel", bus2.select, exp_pick);
        check("t4_next_const", bus2.select, 0);
        $display("t4 next grant=%0d", bus2.select);
        bus2.in_valid = 4'b0001;
        bus2.in_last  = 4'b0001;
        tick();
        check("t4_req0_done", bus2.busy, 0);
        bus2.in_valid = 4'h0;
        bus2.in_last  = 4'h0;

        // 5: A=1, both always valid, 1-beat packets; then counter saturation
        bus1.in_valid  = 2'b11;
        bus1.in_last   = 2'b11;
        bus1.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_select", bus1.select, (k % 2 == 0) ? 1 : 0);
            check("t5_busy", bus1.busy, 1);
            check("t5_ready", bus1.in_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
            $display("t5 packet %0d granted=%0d", k, bus1.select);
            tick();
            check("t5_idle", bus1.busy, 0);
        end
        bus1.in_valid = 2'b01;
        bus1.in_last  = 2'b00;
        tick();
        check("t5_sat_sel", bus1.select, 0);
        for (int k = 1; k <= 9; k++) begin
            tick();
            check("t5_sat_cnt", bus1.beat_cnt, (k > 7) ? 7 : k);
        end
        bus1.in_last = 2'b01;
        tick();
        check("t5_sat_done_busy", bus1.busy, 0);
        check("t5_sat_done_cnt", bus1.beat_cnt, 0);
        bus1.in_valid = 2'b00;
        bus1.in_last  = 2'b00;

        // 6: reset in the middle of a packet
        bus2.in_valid = 4'b0010;
        bus2.in_last  = 4'b0010;
        tick();
        check("t6_pre_sel", bus2.select, 1);
        tick();
        check("t6_pre_done", bus2.busy, 0);
        bus2.in_valid = 4'b0110;
        bus2.in_last  = 4'b0000;
        tick();
        check("t6_sel", bus2.select, 2);
        tick();
        check("t6_cnt", bus2.beat_cnt, 1);
        check("t6_oval", bus2.out_valid, 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("t6_rst_busy", bus2.busy, 0);
        check("t6_rst_ready", bus2.in_ready, 0);
        check("t6_rst_oval", bus2.out_valid, 0);
        check("t6_rst_olast", bus2.out_last, 0);
        check("t6_rst_sel", bus2.select, 0);
        check("t6_rst_cnt", bus2.beat_cnt, 0);
        $display("t6 async reset busy=%0b select=%0d cnt=%0d", bus2.busy, bus2.select, bus2.beat_cnt);
        tick();
        tick();
        check("t6_hold_busy", bus2.busy, 0);
        aresetn = 1'b1;
        tick();
        check("t6_post_sel", bus2.select, 1);
        check("t6_post_busy", bus2.busy, 1);
        $display("t6 first grant after reset=%0d", bus2.select);
        bus2.in_last = 4'b0010;
        tick();
        check("t6_post_done", bus2.busy, 0);
        bus2.in_valid = 4'h0;
        bus2.in_last  = 4'h0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
